// File: rtl/cop_pkg.sv
// cop_pkg: opcodes, FSM state encoding and latency lookup
// shared by the coprocessor issue unit and its sub-blocks.
package cop_pkg;

    localparam logic [5:0] OP_NOP = 6'b000000;
    localparam logic [5:0] OP_ADD = 6'b110000;
    localparam logic [5:0] OP_SUB = 6'b110001;
    localparam logic [5:0] OP_MUL = 6'b110010;
    localparam logic [5:0] OP_DIV = 6'b110011;
    localparam logic [5:0] OP_CMP = 6'b110100;
    localparam logic [5:0] OP_REV = 6'b110101;
    localparam logic [5:0] OP_RND = 6'b110110;
    localparam logic [5:0] OP_LW  = 6'b110111;
    localparam logic [5:0] OP_SW  = 6'b111000;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_EXEC,
        ST_LW_REQ,
        ST_LW_WAIT,
        ST_LW_WR,
        ST_SW_RD,
        ST_SW_CAP,
        ST_SW_REQ
    } cop_state_t;

    // Occupancy of the coprocessor for an arithmetic/misc opcode.
    function automatic logic [4:0] op_latency(
        input logic [5:0]  op,
        input int unsigned addsub_lat,
        input int unsigned mul_lat,
        input int unsigned div_lat,
        input int unsigned misc_lat
    );
        int unsigned lat;
        case (op)
            OP_ADD, OP_SUB: lat = addsub_lat;
            OP_MUL:         lat = mul_lat;
            OP_DIV:         lat = div_lat;
            default:        lat = misc_lat;
        endcase
        return lat[4:0];
    endfunction

endpackage

// File: rtl/cop_issue_unit_if.sv
// cop_issue_unit_if: CPU decode, coprocessor and data-memory
// pins of the issue unit bundled into one interface.
interface cop_issue_unit_if;

    logic        instr_valid;
    logic [31:0] instr;
    logic [31:0] instr_ea;
    logic        instr_ready;
    logic        illegal_op;
    logic [5:0]  cop_opcode;
    logic [4:0]  cop_addr_in1;
    logic [4:0]  cop_addr_in2;
    logic [4:0]  cop_addr_dest;
    logic [31:0] cop_wdata;
    logic [31:0] cop_rdata;
    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic        mem_gnt;
    logic        mem_rvalid;
    logic [31:0] mem_rdata;

    modport master (
        input  instr_valid, instr, instr_ea, cop_rdata,
        input  mem_gnt, mem_rvalid, mem_rdata,
        output instr_ready, illegal_op, cop_opcode,
        output cop_addr_in1, cop_addr_in2, cop_addr_dest,
        output cop_wdata, mem_req, mem_we, mem_addr, mem_wdata
    );

    modport slave (
        output instr_valid, instr, instr_ea, cop_rdata,
        output mem_gnt, mem_rvalid, mem_rdata,
        input  instr_ready, illegal_op, cop_opcode,
        input  cop_addr_in1, cop_addr_in2, cop_addr_dest,
        input  cop_wdata, mem_req, mem_we, mem_addr, mem_wdata
    );

endinterface

// File: rtl/cop_busy_timer.sv
// cop_busy_timer: down-counter holding the issue unit in EXEC
// while the coprocessor is occupied.
module cop_busy_timer (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       load,
    input  logic [4:0] load_val,
    output logic       busy,
    output logic       done
);

    logic [4:0] cnt_q, cnt_d;

    // Reload on issue, otherwise count down to zero and hold.
    always_comb begin
        cnt_d = cnt_q;
        if (load) begin
            cnt_d = load_val;
        end else if (cnt_q != 5'd0) begin
            cnt_d = cnt_q - 5'd1;
        end
    end

    // Counter state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) cnt_q <= 5'd0;
        else        cnt_q <= cnt_d;
    end

    assign busy = (cnt_q != 5'd0);
    assign done = (cnt_q == 5'd0);

endmodule

// File: rtl/cop_issue_unit.sv
// cop_issue_unit: issues coprocessor opcodes from CPU decode,
// sequences lws/sws through the data port, stalls for latency.
module cop_issue_unit
    import cop_pkg::*;
#(
    parameter int unsigned ADDSUB_LAT = 2,
    parameter int unsigned MUL_LAT    = 4,
    parameter int unsigned DIV_LAT    = 12,
    parameter int unsigned MISC_LAT   = 1
) (
    input logic              clk,
    input logic              rst_n,
    cop_issue_unit_if.master bus
);

    cop_state_t  state_q, state_d;
    logic [4:0]  fd_q, fs_q, ft_q;
    logic [31:0] ea_q;
    logic [5:0]  opcode_q, opcode_d;
    logic        illegal_q, illegal_d;
    logic        ready_q, ready_d;
    logic        req_q, req_d;
    logic        we_q, we_d;
    logic [31:0] cwdata_q, cwdata_d;
    logic [31:0] mwdata_q, mwdata_d;

    logic [5:0]  op;
    logic [4:0]  lat;
    logic        accept;
    logic        is_exec;
    logic        tmr_load;
    logic        tmr_done;
    logic        unused_busy;
    logic        unused_bits;

    assign op      = bus.instr[31:26];
    assign accept  = bus.instr_valid & ready_q;
    assign is_exec = (op >= OP_ADD) && (op <= OP_RND);
    assign lat     = op_latency(op, ADDSUB_LAT, MUL_LAT,
                                DIV_LAT, MISC_LAT);
    assign unused_bits = ^bus.instr[10:0];

    cop_busy_timer u_timer (
        .clk      (clk),
        .rst_n    (rst_n),
        .load     (tmr_load),
        .load_val (lat - 5'd1),
        .busy     (unused_busy),
        .done     (tmr_done)
    );

    // Next state and next registered outputs.
    always_comb begin
        state_d   = state_q;
        opcode_d  = OP_NOP;
        illegal_d = 1'b0;
        tmr_load  = 1'b0;
        cwdata_d  = cwdata_q;
        mwdata_d  = mwdata_q;
        unique case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    if (is_exec) begin
                        state_d  = ST_EXEC;
                        opcode_d = op;
                        tmr_load = 1'b1;
                    end else if (op == OP_LW) begin
                        state_d = ST_LW_REQ;
                    end else if (op == OP_SW) begin
                        state_d  = ST_SW_RD;
                        opcode_d = OP_SW;
                    end else begin
                        illegal_d = 1'b1;
                    end
                end
            end
            ST_EXEC: begin
                if (tmr_done) state_d = ST_IDLE;
            end
            ST_LW_REQ: begin
                if (bus.mem_gnt) begin
                    if (bus.mem_rvalid) begin
                        state_d  = ST_LW_WR;
                        opcode_d = OP_LW;
                        cwdata_d = bus.mem_rdata;
                    end else begin
                        state_d = ST_LW_WAIT;
                    end
                end
            end
            ST_LW_WAIT: begin
                if (bus.mem_rvalid) begin
                    state_d  = ST_LW_WR;
                    opcode_d = OP_LW;
                    cwdata_d = bus.mem_rdata;
                end
            end
            ST_LW_WR:  state_d = ST_IDLE;
            ST_SW_RD:  state_d = ST_SW_CAP;
            ST_SW_CAP: begin
                mwdata_d = bus.cop_rdata;
                state_d  = ST_SW_REQ;
            end
            ST_SW_REQ: begin
                if (bus.mem_gnt) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
        ready_d = (state_d == ST_IDLE);
        req_d   = (state_d == ST_LW_REQ) || (state_d == ST_SW_REQ);
        we_d    = (state_d == ST_SW_REQ);
    end

    // FSM and output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_IDLE;
            opcode_q  <= OP_NOP;
            illegal_q <= 1'b0;
            ready_q   <= 1'b1;
            req_q     <= 1'b0;
            we_q      <= 1'b0;
            cwdata_q  <= 32'd0;
            mwdata_q  <= 32'd0;
        end else begin
            state_q   <= state_d;
            opcode_q  <= opcode_d;
            illegal_q <= illegal_d;
            ready_q   <= ready_d;
            req_q     <= req_d;
            we_q      <= we_d;
            cwdata_q  <= cwdata_d;
            mwdata_q  <= mwdata_d;
        end
    end

    // Operand fields and address captured on every accept.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fd_q <= 5'd0;
            fs_q <= 5'd0;
            ft_q <= 5'd0;
            ea_q <= 32'd0;
        end else if (accept) begin
            fd_q <= bus.instr[25:21];
            fs_q <= bus.instr[20:16];
            ft_q <= bus.instr[15:11];
            ea_q <= bus.instr_ea;
        end
    end

    assign bus.instr_ready   = ready_q;
    assign bus.illegal_op    = illegal_q;
    assign bus.cop_opcode    = opcode_q;
    assign bus.cop_addr_in1  = fs_q;
    assign bus.cop_addr_in2  = ft_q;
    assign bus.cop_addr_dest = fd_q;
    assign bus.cop_wdata     = cwdata_q;
    assign bus.mem_req       = req_q;
    assign bus.mem_we        = we_q;
    assign bus.mem_addr      = ea_q;
    assign bus.mem_wdata     = mwdata_q;

endmodule

// File: tb/tb_cop_issue_unit.sv
// tb_cop_issue_unit: randomized scenarios for the coprocessor
// issue unit checked against a behavioural expectation model.
module tb_cop_issue_unit;

    localparam int ADDSUB_LAT = 2;
    localparam int MUL_LAT    = 4;
    localparam int DIV_LAT    = 12;
    localparam int MISC_LAT   = 1;

    localparam logic [5:0] C_ADD = 6'b110000;
    localparam logic [5:0] C_DIV = 6'b110011;
    localparam logic [5:0] C_LW  = 6'b110111;
    localparam logic [5:0] C_SW  = 6'b111000;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int n_cmp = 0;
    int n_err = 0;
    logic [31:0] exp_wdata = 32'd0;

    cop_issue_unit_if bus();

    cop_issue_unit #(
        .ADDSUB_LAT (ADDSUB_LAT),
        .MUL_LAT    (MUL_LAT),
        .DIV_LAT    (DIV_LAT),
        .MISC_LAT   (MISC_LAT)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    // Reference: how many cycles each opcode keeps the unit busy.
    function automatic int lat_of(input logic [5:0] op);
        if (op == 6'b110000 || op == 6'b110001) return ADDSUB_LAT;
        if (op == 6'b110010) return MUL_LAT;
        if (op == 6'b110011) return DIV_LAT;
        return MISC_LAT;
    endfunction

    task automatic idle_inputs();
        bus.instr_valid = 1'b0;
        bus.instr       = 32'd0;
        bus.instr_ea    = 32'd0;
        bus.cop_rdata   = 32'd0;
        bus.mem_gnt     = 1'b0;
        bus.mem_rvalid  = 1'b0;
        bus.mem_rdata   = 32'd0;
    endtask

    // Present one instruction at a negedge; returns at the negedge after accept.
    task automatic issue(input logic [5:0] op, input logic [4:0] fd,
                         input logic [4:0] fs, input logic [4:0] ft,
                         input logic [31:0] ea);
        bus.instr_valid = 1'b1;
        bus.instr       = {op, fd, fs, ft, 11'($urandom)};
        bus.instr_ea    = ea;
        @(posedge clk);
        @(negedge clk);
        bus.instr_valid = 1'b0;
        bus.instr       = $urandom;
        bus.instr_ea    = $urandom;
    endtask

    task automatic test_reset();
        idle_inputs();
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        n_cmp++;
        if (bus.instr_ready !== 1'b1) begin
            n_err++; $display("FAIL reset_ready got %b want 1", bus.instr_ready);
        end
        n_cmp++;
        if ({bus.cop_opcode, bus.illegal_op, bus.mem_req, bus.mem_we} !== 9'd0) begin
            n_err++; $display("FAIL reset_ctrl got op=%b ill=%b req=%b we=%b want 0",
                              bus.cop_opcode, bus.illegal_op, bus.mem_req, bus.mem_we);
        end
        n_cmp++;
        if ({bus.mem_addr, bus.mem_wdata, bus.cop_wdata} !== 96'd0 ||
            {bus.cop_addr_in1, bus.cop_addr_in2, bus.cop_addr_dest} !== 15'd0) begin
            n_err++; $display("FAIL reset_data got addr=%h wd=%h cw=%h want 0",
                              bus.mem_addr, bus.mem_wdata, bus.cop_wdata);
        end
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_arith();
        for (int i = 0; i < 14; i++) begin
            logic [5:0] op;
            logic [4:0] fd, fs, ft;
            int busy, pulses;
            logic bad;
            if (i == 0) begin
                op = C_ADD; fd = 5'd3; fs = 5'd1; ft = 5'd2;
            end else begin
                op = C_ADD + 6'($urandom_range(0, 6));
                fd = 5'($urandom); fs = 5'($urandom); ft = 5'($urandom);
            end
            issue(op, fd, fs, ft, $urandom);
            busy = 0; pulses = 0; bad = 1'b0;
            while (bus.instr_ready !== 1'b1 && busy < 40) begin
                busy++;
                if (bus.cop_opcode !== 6'd0) begin
                    pulses++;
                    if (bus.cop_opcode !== op || busy != 1) bad = 1'b1;
                end
                @(negedge clk);
            end
            n_cmp++;
            if (busy != lat_of(op)) begin
                n_err++; $display("FAIL arith_latency op=%b got %0d want %0d", op, busy, lat_of(op));
            end
            n_cmp++;
            if (pulses != 1 || bad) begin
                n_err++; $display("FAIL arith_pulse op=%b got %0d pulses (misplaced=%b) want 1", op, pulses, bad);
            end
            n_cmp++;
            if ({bus.cop_addr_dest, bus.cop_addr_in1, bus.cop_addr_in2} !== {fd, fs, ft}) begin
                n_err++; $display("FAIL arith_addr got %0d/%0d/%0d want %0d/%0d/%0d",
                                  bus.cop_addr_dest, bus.cop_addr_in1, bus.cop_addr_in2, fd, fs, ft);
            end
            n_cmp++;
            if (bus.cop_opcode !== 6'd0 || bus.mem_req !== 1'b0 || bus.cop_wdata !== exp_wdata) begin
                n_err++; $display("FAIL arith_idle got op=%b req=%b cw=%h want 0/0/%h",
                                  bus.cop_opcode, bus.mem_req, bus.cop_wdata, exp_wdata);
            end
        end
    endtask

    task automatic test_back_to_back();
        int gap, drain;
        logic bad;
        gap = 0; drain = 0; bad = 1'b0;
        bus.instr_valid = 1'b1;
        bus.instr       = {C_DIV, 5'd4, 5'd5, 5'd6, 11'd0};
        bus.instr_ea    = 32'd0;
        @(posedge clk);
        @(negedge clk);
        bus.instr = {C_ADD, 5'd7, 5'd8, 5'd9, 11'd0};
        n_cmp++;
        if (bus.cop_opcode !== C_DIV) begin
            n_err++; $display("FAIL b2b_div_op got %b want %b", bus.cop_opcode, C_DIV);
        end
        while (bus.instr_ready !== 1'b1 && gap < 40) begin
            gap++;
            if (gap > 1 && bus.cop_opcode !== 6'd0) bad = 1'b1;
            @(negedge clk);
        end
        n_cmp++;
        if (gap != DIV_LAT) begin
            n_err++; $display("FAIL b2b_gap got %0d busy cycles want %0d", gap, DIV_LAT);
        end
        n_cmp++;
        if (bad || bus.cop_opcode !== 6'd0) begin
            n_err++; $display("FAIL b2b_overlap got op=%b stray=%b want 0/0", bus.cop_opcode, bad);
        end
        @(posedge clk);
        @(negedge clk);
        bus.instr_valid = 1'b0;
        n_cmp++;
        if (bus.cop_opcode !== C_ADD || bus.cop_addr_dest !== 5'd7 || bus.instr_ready !== 1'b0) begin
            n_err++; $display("FAIL b2b_add got op=%b dest=%0d rdy=%b want %b/7/0",
                              bus.cop_opcode, bus.cop_addr_dest, bus.instr_ready, C_ADD);
        end
        while (bus.instr_ready !== 1'b1 && drain < 40) begin
            drain++;
            @(negedge clk);
        end
    endtask

    task automatic test_lw(input logic [31:0] ea, input logic [4:0] fd,
                           input logic [31:0] data, input int gnt_dly, input int rv_dly);
        int stray;
        stray = 0;
        issue(C_LW, fd, 5'($urandom), 5'($urandom), ea);
        n_cmp++;
        if ({bus.mem_req, bus.mem_we} !== 2'b10 || bus.mem_addr !== ea) begin
            n_err++; $display("FAIL lw_req got req=%b we=%b addr=%h want 1/0/%h",
                              bus.mem_req, bus.mem_we, bus.mem_addr, ea);
        end
        for (int c = 0; c < gnt_dly; c++) begin
            if (bus.mem_req !== 1'b1 || bus.cop_opcode !== 6'd0) stray++;
            @(negedge clk);
        end
        bus.mem_gnt = 1'b1;
        if (rv_dly == 0) begin
            bus.mem_rvalid = 1'b1;
            bus.mem_rdata  = data;
        end
        @(negedge clk);
        bus.mem_gnt    = 1'b0;
        bus.mem_rvalid = 1'b0;
        bus.mem_rdata  = ~data;
        if (rv_dly > 0) begin
            for (int c = 1; c < rv_dly; c++) begin
                if (bus.mem_req !== 1'b0 || bus.cop_opcode !== 6'd0) stray++;
                @(negedge clk);
            end
            if (bus.mem_req !== 1'b0 || bus.cop_opcode !== 6'd0) stray++;
            bus.mem_rvalid = 1'b1;
            bus.mem_rdata  = data;
            @(negedge clk);
            bus.mem_rvalid = 1'b0;
            bus.mem_rdata  = ~data;
        end
        exp_wdata = data;
        n_cmp++;
        if (bus.cop_opcode !== C_LW || bus.cop_addr_dest !== fd ||
            bus.cop_wdata !== data || bus.mem_req !== 1'b0) begin
            n_err++; $display("FAIL lw_write got op=%b dest=%0d cw=%h req=%b want %b/%0d/%h/0",
                              bus.cop_opcode, bus.cop_addr_dest, bus.cop_wdata, bus.mem_req, C_LW, fd, data);
        end
        n_cmp++;
        if (stray != 0) begin
            n_err++; $display("FAIL lw_wait got %0d bad wait cycles want 0 (gnt=%0d rv=%0d)",
                              stray, gnt_dly, rv_dly);
        end
        @(negedge clk);
        n_cmp++;
        if (bus.cop_opcode !== 6'd0 || bus.instr_ready !== 1'b1 || bus.cop_wdata !== data) begin
            n_err++; $display("FAIL lw_done got op=%b rdy=%b cw=%h want 0/1/%h",
                              bus.cop_opcode, bus.instr_ready, bus.cop_wdata, data);
        end
    endtask

    task automatic test_sw(input logic [4:0] fs, input logic [31:0] ea,
                           input logic [31:0] data, input int gnt_dly);
        int stray;
        stray = 0;
        issue(C_SW, 5'($urandom), fs, 5'($urandom), ea);
        n_cmp++;
        if (bus.cop_opcode !== C_SW || bus.cop_addr_in1 !== fs || bus.mem_req !== 1'b0) begin
            n_err++; $display("FAIL sw_read got op=%b in1=%0d req=%b want %b/%0d/0",
                              bus.cop_opcode, bus.cop_addr_in1, bus.mem_req, C_SW, fs);
        end
        bus.cop_rdata = ~data;
        @(posedge clk);
        #1 bus.cop_rdata = data;
        @(posedge clk);
        #1 bus.cop_rdata = ~data;
        @(negedge clk);
        n_cmp++;
        if ({bus.mem_req, bus.mem_we} !== 2'b11 || bus.mem_addr !== ea ||
            bus.mem_wdata !== data || bus.cop_opcode !== 6'd0) begin
            n_err++; $display("FAIL sw_req got req=%b we=%b addr=%h wd=%h op=%b want 1/1/%h/%h/0",
                              bus.mem_req, bus.mem_we, bus.mem_addr, bus.mem_wdata, bus.cop_opcode, ea, data);
        end
        for (int c = 0; c < gnt_dly; c++) begin
            @(negedge clk);
            if (bus.mem_req !== 1'b1 || bus.mem_we !== 1'b1 || bus.mem_wdata !== data) stray++;
        end
        bus.mem_gnt = 1'b1;
        @(negedge clk);
        bus.mem_gnt = 1'b0;
        n_cmp++;
        if (stray != 0) begin
            n_err++; $display("FAIL sw_hold got %0d bad cycles want 0", stray);
        end
        n_cmp++;
        if (bus.mem_req !== 1'b0 || bus.instr_ready !== 1'b1 || bus.cop_wdata !== exp_wdata) begin
            n_err++; $display("FAIL sw_done got req=%b rdy=%b cw=%h want 0/1/%h",
                              bus.mem_req, bus.instr_ready, bus.cop_wdata, exp_wdata);
        end
    endtask

    task automatic test_illegal();
        for (int i = 0; i < 6; i++) begin
            logic [5:0] op;
            if (i == 0) begin
                op = 6'b111111;
            end else begin
                do op = 6'($urandom); while (op >= 6'b110000 && op <= 6'b111000);
            end
            issue(op, 5'($urandom), 5'($urandom), 5'($urandom), $urandom);
            n_cmp++;
            if (bus.illegal_op !== 1'b1 || bus.cop_opcode !== 6'd0 || bus.instr_ready !== 1'b1) begin
                n_err++; $display("FAIL illegal_pulse op=%b got ill=%b op=%b rdy=%b want 1/0/1",
                                  op, bus.illegal_op, bus.cop_opcode, bus.instr_ready);
            end
            @(negedge clk);
            n_cmp++;
            if (bus.illegal_op !== 1'b0 || bus.instr_ready !== 1'b1 || bus.mem_req !== 1'b0) begin
                n_err++; $display("FAIL illegal_after got ill=%b rdy=%b req=%b want 0/1/0",
                                  bus.illegal_op, bus.instr_ready, bus.mem_req);
            end
        end
    endtask

    task automatic test_reset_mid_lw();
        int pulses;
        pulses = 0;
        issue(C_LW, 5'd9, 5'd0, 5'd0, 32'h0000_0200);
        bus.mem_gnt = 1'b1;
        @(negedge clk);
        bus.mem_gnt = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        n_cmp++;
        if (bus.instr_ready !== 1'b1 || bus.mem_req !== 1'b0 || bus.cop_opcode !== 6'd0 ||
            bus.cop_wdata !== 32'd0 || bus.mem_addr !== 32'd0 || bus.cop_addr_dest !== 5'd0) begin
            n_err++; $display("FAIL rstmid_async got rdy=%b req=%b op=%b cw=%h want 1/0/0/0",
                              bus.instr_ready, bus.mem_req, bus.cop_opcode, bus.cop_wdata);
        end
        exp_wdata = 32'd0;
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        bus.mem_rvalid = 1'b1;
        bus.mem_rdata  = 32'hDEAD_BEEF;
        @(negedge clk);
        bus.mem_rvalid = 1'b0;
        repeat (4) begin
            if (bus.cop_opcode !== 6'd0) pulses++;
            @(negedge clk);
        end
        n_cmp++;
        if (pulses != 0 || bus.cop_wdata !== 32'd0 || bus.instr_ready !== 1'b1) begin
            n_err++; $display("FAIL rstmid_stale got pulses=%0d cw=%h rdy=%b want 0/0/1",
                              pulses, bus.cop_wdata, bus.instr_ready);
        end
    endtask

    initial begin
        test_reset();
        test_arith();
        test_back_to_back();
        test_lw(32'h0000_0100, 5'd5, 32'h3F80_0000, 3, 2);
        test_lw(32'h0000_0104, 5'd6, 32'h1234_5678, 0, 0);
        for (int i = 0; i < 5; i++) begin
            test_lw($urandom, 5'($urandom), $urandom,
                    $urandom_range(0, 3), $urandom_range(0, 3));
        end
        test_sw(5'd7, 32'h0000_0300, 32'h4049_0FDB, 2);
        for (int i = 0; i < 4; i++) begin
            test_sw(5'($urandom), $urandom, $urandom, $urandom_range(0, 3));
        end
        test_illegal();
        test_reset_mid_lw();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog got timeout want completion");
        $fatal(1, "timeout");
    end

endmodule
